// File: rtl/obc_shift_accumulator.sv
// Bit-serial OBC shift-accumulate stage: sums four ROM words per bit, accumulates LSB-first, adds offset.
// Optional saturation of the final result is enabled by defining OBC_SAT_EN.
module obc_shift_accumulator #(
  parameter int          NBITS  = 16,
  parameter logic [31:0] OFFSET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        bit_valid,
  input  logic [31:0] rom_out0,
  input  logic [31:0] rom_out1,
  input  logic [31:0] rom_out2,
  input  logic [31:0] rom_out3,
  output logic        busy,
  output logic [4:0]  bit_idx,
  output logic [31:0] y_out,
  output logic        y_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic signed [35:0] acc_r, acc_s;
  logic signed [35:0] psum_ext_s, sum_s, fin_s;
  logic [33:0]        psum_s;
  logic [4:0]         idx_s;
  logic [31:0]        y_s;
  logic               yv_s, busy_s;

  // Narrow the 36b accumulator to the 32b Q10.21 output format.
  function automatic logic [31:0] fmt(input logic signed [35:0] v);
    logic [31:0] r;
`ifdef OBC_SAT_EN
    if (v[35:31] == {5{v[35]}}) begin
      r = v[31:0];
    end else if (v[35]) begin
      r = 32'h8000_0000;
    end else begin
      r = 32'h7FFF_FFFF;
    end
`else
    r = v[31:0];
`endif
    return r;
  endfunction

  assign psum_s = {{2{rom_out0[31]}}, rom_out0} + {{2{rom_out1[31]}}, rom_out1}
                + {{2{rom_out2[31]}}, rom_out2} + {{2{rom_out3[31]}}, rom_out3};
  assign psum_ext_s = {{2{psum_s[33]}}, psum_s};
  assign sum_s      = acc_r + psum_ext_s;
  assign fin_s      = acc_r + {{4{OFFSET[31]}}, OFFSET};

  // Next-state, accumulator and result logic.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    idx_s   = bit_idx;
    y_s     = y_out;
    yv_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          acc_s   = 36'sd0;
          idx_s   = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (start) begin
          acc_s = 36'sd0;
          idx_s = 5'd0;
        end else if (bit_valid) begin
          // The MSB carries negative weight in two's complement, so it is subtracted unshifted.
          if (bit_idx == 5'(NBITS - 1)) begin
            acc_s   = acc_r - psum_ext_s;
            idx_s   = 5'd0;
            state_s = DONE;
          end else begin
            acc_s = sum_s >>> 1;
            idx_s = bit_idx + 5'd1;
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s = RUN;
          acc_s   = 36'sd0;
          idx_s   = 5'd0;
        end else begin
          state_s = IDLE;
          y_s     = fmt(fin_s);
          yv_s    = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = 36'sd0;
        idx_s   = 5'd0;
      end
    endcase
    busy_s = (state_s == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= 36'sd0;
      bit_idx <= 5'd0;
      y_out   <= 32'h0000_0000;
      y_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      bit_idx <= idx_s;
      y_out   <= y_s;
      y_valid <= yv_s;
      busy    <= busy_s;
    end
  end

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Bench for obc_shift_accumulator: three instances (NBITS/OFFSET variants) against a frame-level model.
module tb_obc_shift_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bit_valid = 1'b0;
  logic [31:0] r0 = 32'h0, r1 = 32'h0, r2 = 32'h0, r3 = 32'h0;

  logic        busy_w [3];
  logic [4:0]  idx_w  [3];
  logic [31:0] y_w    [3];
  logic        yv_w   [3];

  int nvec = 0;
  int nerr = 0;
  bit started = 1'b0;
  int cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  obc_shift_accumulator #(.NBITS(4), .OFFSET(32'h0000_0000)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .rom_out0(r0), .rom_out1(r1), .rom_out2(r2), .rom_out3(r3),
    .busy(busy_w[0]), .bit_idx(idx_w[0]), .y_out(y_w[0]), .y_valid(yv_w[0]));
  obc_shift_accumulator #(.NBITS(4), .OFFSET(32'h0010_0000)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .rom_out0(r0), .rom_out1(r1), .rom_out2(r2), .rom_out3(r3),
    .busy(busy_w[1]), .bit_idx(idx_w[1]), .y_out(y_w[1]), .y_valid(yv_w[1]));
  obc_shift_accumulator #(.NBITS(2), .OFFSET(32'h0000_0000)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .rom_out0(r0), .rom_out1(r1), .rom_out2(r2), .rom_out3(r3),
    .busy(busy_w[2]), .bit_idx(idx_w[2]), .y_out(y_w[2]), .y_valid(yv_w[2]));

  // Frame-level model: weighted bit sum with floor halving, result delivered one cycle after completion.
  int          nb_m  [3] = '{4, 4, 2};
  longint      off_m [3] = '{64'sd0, 64'sd1048576, 64'sd0};
  longint      macc  [3] = '{64'sd0, 64'sd0, 64'sd0};
  int          midx  [3] = '{0, 0, 0};
  bit          mrun  [3] = '{1'b0, 1'b0, 1'b0};
  bit          mdone [3] = '{1'b0, 1'b0, 1'b0};
  bit          myv   [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] my    [3] = '{32'h0, 32'h0, 32'h0};

  function automatic longint psum_m();
    return longint'($signed(r0)) + longint'($signed(r1)) + longint'($signed(r2)) + longint'($signed(r3));
  endfunction

  function automatic logic [31:0] fmt_m(input longint s);
`ifdef OBC_SAT_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Model update on every clock edge and on asynchronous reset.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        macc[i] <= 64'sd0; midx[i] <= 0; mrun[i] <= 1'b0;
        mdone[i] <= 1'b0; myv[i] <= 1'b0; my[i] <= 32'h0;
      end else begin
        myv[i] <= 1'b0;
        if (start) begin
          mrun[i] <= 1'b1; mdone[i] <= 1'b0; midx[i] <= 0; macc[i] <= 64'sd0;
        end else if (mdone[i]) begin
          my[i] <= fmt_m(macc[i] + off_m[i]); myv[i] <= 1'b1; mdone[i] <= 1'b0;
        end else if (mrun[i] && bit_valid) begin
          if (midx[i] == nb_m[i] - 1) begin
            macc[i] <= macc[i] - psum_m(); midx[i] <= 0; mrun[i] <= 1'b0; mdone[i] <= 1'b1;
          end else begin
            macc[i] <= (macc[i] + psum_m()) >>> 1; midx[i] <= midx[i] + 1;
          end
        end
      end
    end
  end

  // Result pulse counter per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (yv_w[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", i), {31'd0, busy_w[i]}, {31'd0, mrun[i]});
        chk($sformatf("bit_idx%0d", i), {27'd0, idx_w[i]}, 32'(midx[i]));
        chk($sformatf("y_valid%0d", i), {31'd0, yv_w[i]}, {31'd0, myv[i]});
        chk($sformatf("y_out%0d", i), y_w[i], my[i]);
      end
    end
  end

  task automatic cyc(input logic s, input logic bv, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [31:0] d);
    start = s; bit_valid = bv; r0 = a; r1 = b; r2 = c; r3 = d;
    @(posedge clk); #1;
  endtask

  task automatic bitw(input logic [31:0] w);
    cyc(1'b0, 1'b1, w, w, w, w);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic go();
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    chk("reset_busy", {31'd0, busy_w[0]}, 32'h0);
    chk("reset_idx", {27'd0, idx_w[0]}, 32'h0);
    chk("reset_y", y_w[0], 32'h0);
    chk("reset_yv", {31'd0, yv_w[0]}, 32'h0);

    // T1/T2: psum 4.0 over four bits -> -0.5; with +0.5 offset -> 0; NBITS=2 instance -> -2.0
    go();
    for (int k = 0; k < 4; k++) bitw(32'h0020_0000);
    chk("t1_lat_done", {31'd0, yv_w[0]}, 32'h0);
    idle(1);
    chk("t1_lat_pulse", {31'd0, yv_w[0]}, 32'h1);
    idle(1);
    chk("t2_one_cycle", {31'd0, yv_w[1]}, 32'h0);
    idle(1);
    chk("t1_y", y_w[0], 32'hFFF0_0000);
    chk("t2_y", y_w[1], 32'h0000_0000);
    chk("t1_n2_y", y_w[2], 32'hFFC0_0000);

    // T4: maximum positive words on the NBITS=2 instance
    go();
    for (int k = 0; k < 2; k++) bitw(32'h7FFF_FFFF);
    idle(3);
`ifdef OBC_SAT_EN
    chk("t4_y", y_w[2], 32'h8000_0000);
`else
    chk("t4_y", y_w[2], 32'h0000_0002);
`endif

    // T3: three stall cycles between bits 1 and 2
    go();
    for (int k = 0; k < 2; k++) bitw(32'h0020_0000);
    idle(3);
    chk("t3_idx_frozen", {27'd0, idx_w[0]}, 32'd2);
    chk("t3_busy_held", {31'd0, busy_w[0]}, 32'h1);
    for (int k = 0; k < 2; k++) bitw(32'h0020_0000);
    idle(3);
    chk("t3_y", y_w[0], 32'hFFF0_0000);

    // T5: abort after two bits, then a full frame
    go();
    for (int k = 0; k < 2; k++) bitw(32'h0020_0000);
    go();
    for (int k = 0; k < 4; k++) bitw(32'h0020_0000);
    idle(3);
    chk("t5_y", y_w[0], 32'hFFF0_0000);
    chk("t5_cnt0", 32'(cnt[0]), 32'd3);
    chk("t5_cnt2", 32'(cnt[2]), 32'd4);

    // Mixed-sign distinct words, checked against the model only
    go();
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001 << k, 32'hFFFF_FFFF, 32'h4000_0000 + 32'(k));
    idle(3);

    // Start during the result pulse, together with a bit_valid that must be ignored
    go();
    for (int k = 0; k < 4; k++) bitw(32'h0020_0000);
    idle(1);
    chk("restart_yv", {31'd0, yv_w[0]}, 32'h1);
    cyc(1'b1, 1'b1, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000, 32'h7000_0000);
    for (int k = 0; k < 4; k++) bitw(32'h0020_0000);
    idle(3);
    chk("restart_y", y_w[0], 32'hFFF0_0000);
    chk("restart_cnt0", 32'(cnt[0]), 32'd6);

    // T6: asynchronous reset between edges mid-frame
    go();
    bitw(32'h0020_0000);
    start = 1'b0; bit_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy_w[0]}, 32'h0);
    chk("t6_idx", {27'd0, idx_w[0]}, 32'h0);
    chk("t6_y", y_w[0], 32'h0);
    chk("t6_yv", {31'd0, yv_w[0]}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    go();
    for (int k = 0; k < 4; k++) bitw(32'h0020_0000);
    idle(3);
    chk("t6_after_y", y_w[0], 32'hFFF0_0000);
    chk("t6_cnt0", 32'(cnt[0]), 32'd7);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
